// File: rtl/arbeiter_pkg.sv
// Shared types and constants for the arbeiter_xfer burst engine.
package arbeiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic OWN_0 = 1'b0;
  localparam logic OWN_1 = 1'b1;

endpackage

// File: rtl/arbeiter_beat_cnt.sv
// Loadable burst-length down-counter; flags the final beat of a burst.
module arbeiter_beat_cnt #(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/arbeiter_xfer.sv
// Turns an arbiter grant into a length-counted valid/ready burst on the shared bus.
// Optional ARBEITER_XFER_PARITY_EN adds bus_par, the XOR parity of bus_data.
module arbeiter_xfer
  import arbeiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic [DATA_W-1:0] data_0,
  input  logic [LEN_W-1:0]  len_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [LEN_W-1:0]  len_1,
  output logic              beat_0,
  output logic              beat_1,
  output logic              done_0,
  output logic              done_1,
  output logic              abort,
  output logic              err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_owner,
  output logic              busy
`ifdef ARBEITER_XFER_PARITY_EN
  ,
  output logic              bus_par
`endif
);

  // Handshake: a beat moves when bus_valid && bus_ready in the same cycle;
  // bus_valid stays up through stalls and only drops on completion or abort.
  state_e           state_q;
  logic             owner_q;
  logic             abort_q;
  logic             err_q;
  logic [LEN_W-1:0] sel_len;
  logic             gnt_own;
  logic             accept;
  logic             load;
  logic             cnt_is_one;

  assign sel_len = gnt_0 ? len_0 : len_1;
  assign gnt_own = (owner_q == OWN_1) ? gnt_1 : gnt_0;
  assign accept  = (state_q == BURST) && bus_ready;
  assign load    = (state_q == IDLE) && (gnt_0 || gnt_1);

  arbeiter_beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (load),
    .load_val_i (sel_len),
    .dec_i      (accept),
    .is_one_o   (cnt_is_one)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (gnt_0 && gnt_1) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (gnt_0 || gnt_1) begin
            owner_q <= gnt_0 ? OWN_0 : OWN_1;
            state_q <= (sel_len == '0) ? DONE : BURST;
          end
        end
        BURST: begin
          // A beat accepted on the grant-loss edge still counts; abort only without one.
          if (accept && cnt_is_one) begin
            state_q <= DONE;
          end else if (!accept && !gnt_own) begin
            abort_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        DONE:    state_q <= RELEASE;
        RELEASE: begin
          if (!gnt_own) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_valid = (state_q == BURST);
  assign beat_0    = accept && (owner_q == OWN_0);
  assign beat_1    = accept && (owner_q == OWN_1);
  assign done_0    = (state_q == DONE) && (owner_q == OWN_0);
  assign done_1    = (state_q == DONE) && (owner_q == OWN_1);
  assign bus_data  = bus_valid ? ((owner_q == OWN_1) ? data_1 : data_0) : '0;
  assign bus_owner = owner_q;
  assign busy      = (state_q != IDLE);
  assign abort     = abort_q;
  assign err       = err_q;

`ifdef ARBEITER_XFER_PARITY_EN
  assign bus_par = ^bus_data;
`endif

endmodule

// File: tb/tb_arbeiter_xfer.sv
// Self-checking bench for arbeiter_xfer: cycle table, corner sequences, random bursts.
module tb_arbeiter_xfer;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          gnt_0, gnt_1;
  logic [DW-1:0] data_0, data_1;
  logic [LW-1:0] len_0, len_1;
  logic          beat_0, beat_1, done_0, done_1, abort, err;
  logic          bus_valid, bus_ready, bus_owner, busy;
  logic [DW-1:0] bus_data;
`ifdef ARBEITER_XFER_PARITY_EN
  logic          bus_par;
`endif

  arbeiter_xfer #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clock     (clock),
    .reset     (reset),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .data_0    (data_0),
    .len_0     (len_0),
    .data_1    (data_1),
    .len_1     (len_1),
    .beat_0    (beat_0),
    .beat_1    (beat_1),
    .done_0    (done_0),
    .done_1    (done_1),
    .abort     (abort),
    .err       (err),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_owner (bus_owner),
    .busy      (busy)
`ifdef ARBEITER_XFER_PARITY_EN
    ,
    .bus_par   (bus_par)
`endif
  );

  always #5 clock = ~clock;

  int            n_cmp = 0;
  int            n_err = 0;
  logic          adv_0, adv_1;
  int            nb0, nb1, nd0, nab;
  logic [DW-1:0] exp_q[$];

  // flags order: valid beat_0 beat_1 done_0 done_1 abort err busy owner
  typedef struct packed {
    logic          g0;
    logic          g1;
    logic [LW-1:0] l0;
    logic          rdy;
    logic [8:0]    f;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic g0, input logic g1, input logic [LW-1:0] l0,
                              input logic rdy, input logic [8:0] f, input logic [DW-1:0] d);
    vec_t v;
    v.g0 = g0; v.g1 = g1; v.l0 = l0; v.rdy = rdy; v.f = f; v.d = d;
    return v;
  endfunction

  function automatic logic [8:0] flags();
    return {bus_valid, beat_0, beat_1, done_0, done_1, abort, err, busy, bus_owner};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    if (adv_0) data_0 = data_0 + 1'b1;
    if (adv_1) data_1 = data_1 + 1'b1;
    adv_0 = 1'b0;
    adv_1 = 1'b0;
  endtask

  task automatic samp();
    @(negedge clock);
    adv_0 = beat_0;
    adv_1 = beat_1;
    nb0 += int'(beat_0);
    nb1 += int'(beat_1);
    nd0 += int'(done_0);
    nab += int'(abort);
  endtask

  task automatic clr_counts();
    nb0 = 0; nb1 = 0; nd0 = 0; nab = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            o, len, h, cycles;
    logic [DW-1:0] base;
    logic          first, done_due, fin, got_beat, got_done, oth_beat, oth_done;

    reset = 1'b0; gnt_0 = 0; gnt_1 = 0; data_0 = '0; data_1 = '0;
    len_0 = '0; len_1 = '0; bus_ready = 0; adv_0 = 0; adv_1 = 0;
    clr_counts();

    // test 1 (len 3), test 3 (len 0), test 4 (both grants -> err, client 0 owns)
    tbl[0]  = mk(1, 0, 3, 1, 9'b000000000, 8'h00);
    tbl[1]  = mk(1, 0, 3, 1, 9'b110000010, 8'hA5);
    tbl[2]  = mk(1, 0, 3, 1, 9'b110000010, 8'hA5);
    tbl[3]  = mk(1, 0, 3, 1, 9'b110000010, 8'hA5);
    tbl[4]  = mk(0, 0, 3, 1, 9'b000100010, 8'h00);
    tbl[5]  = mk(0, 0, 3, 1, 9'b000000010, 8'h00);
    tbl[6]  = mk(1, 0, 0, 1, 9'b000000000, 8'h00);
    tbl[7]  = mk(1, 0, 0, 1, 9'b000100010, 8'h00);
    tbl[8]  = mk(1, 0, 0, 1, 9'b000000010, 8'h00);
    tbl[9]  = mk(0, 0, 0, 1, 9'b000000010, 8'h00);
    tbl[10] = mk(1, 1, 2, 1, 9'b000000000, 8'h00);
    tbl[11] = mk(1, 1, 2, 1, 9'b110000110, 8'hA5);
    tbl[12] = mk(1, 1, 2, 1, 9'b110000110, 8'hA5);
    tbl[13] = mk(0, 0, 2, 1, 9'b000100110, 8'h00);
    tbl[14] = mk(0, 0, 2, 1, 9'b000000110, 8'h00);
    tbl[15] = mk(0, 0, 2, 1, 9'b000000100, 8'h00);

    #2 reset = 1'b1;
    @(negedge clock);
    chk("reset flags", flags(), 9'b0);
    chk("reset data", bus_data, 8'h00);
    cyc();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc();
      gnt_0 = tbl[i].g0; gnt_1 = tbl[i].g1; len_0 = tbl[i].l0; len_1 = 4'd5;
      bus_ready = tbl[i].rdy; data_0 = 8'hA5; data_1 = 8'h3C;
      samp();
      chk($sformatf("tbl%0d flags", i), flags(), tbl[i].f);
      chk($sformatf("tbl%0d data", i), bus_data, tbl[i].d);
    end

    // test 6: async reset mid-burst clears err, then a 1-beat burst
    cyc();
    gnt_0 = 1; len_0 = 4'd7; bus_ready = 1; data_0 = 8'h20;
    samp();
    cyc();
    samp();
    chk("t6 in burst", bus_valid, 1'b1);
    @(posedge clock);
    #3 reset = 1'b1; gnt_0 = 0;
    #1;
    chk("t6 async reset flags", flags(), 9'b0);
    chk("t6 async reset data", bus_data, 8'h00);
    @(negedge clock);
    adv_0 = 0;
    cyc();
    reset = 1'b0; gnt_0 = 1; len_0 = 4'd1; data_0 = 8'h20;
    samp();
    chk("t6 idle", flags(), 9'b0);
    cyc();
    samp();
    chk("t6 beat", flags(), 9'b110000010);
    chk("t6 data", bus_data, 8'h20);
    cyc();
    gnt_0 = 0;
    samp();
    chk("t6 done", flags(), 9'b000100010);
    cyc();
    samp();
    chk("t6 release", flags(), 9'b000000010);
    cyc();
    samp();
    chk("t6 idle after", busy, 1'b0);

    // test 2: client 1, len 2, two stall cycles
    clr_counts();
    cyc();
    gnt_1 = 1; len_1 = 4'd2; bus_ready = 0; data_1 = 8'h40;
    samp();
    chk("t2 idle", flags(), 9'b0);
    cyc();
    samp();
    chk("t2 stall1", flags(), 9'b100000011);
    chk("t2 stall1 data", bus_data, 8'h40);
    cyc();
    samp();
    chk("t2 stall2", flags(), 9'b100000011);
    chk("t2 stall2 data", bus_data, 8'h40);
    cyc();
    bus_ready = 1;
    samp();
    chk("t2 beat1", flags(), 9'b101000011);
    chk("t2 beat1 data", bus_data, 8'h40);
    cyc();
    samp();
    chk("t2 beat2", flags(), 9'b101000011);
    chk("t2 beat2 data", bus_data, 8'h41);
    cyc();
    samp();
    chk("t2 done", flags(), 9'b000010011);
    cyc();
    samp();
    chk("t2 release hold", flags(), 9'b000000011);
    cyc();
    gnt_1 = 0;
    samp();
    chk("t2 release exit", busy, 1'b1);
    cyc();
    samp();
    chk("t2 idle after", busy, 1'b0);
    chk("t2 beat count", nb1, 2);

    // test 5: grant lost after 2 beats -> abort, then client 1 served
    clr_counts();
    cyc();
    gnt_0 = 1; len_0 = 4'd5; bus_ready = 1; data_0 = 8'h10;
    samp();
    cyc();
    samp();
    chk("t5 beat1 data", bus_data, 8'h10);
    cyc();
    samp();
    chk("t5 beat2 data", bus_data, 8'h11);
    cyc();
    gnt_0 = 0; bus_ready = 0;
    samp();
    chk("t5 stalled", flags(), 9'b100000010);
    cyc();
    gnt_1 = 1; len_1 = 4'd1; data_1 = 8'h77; bus_ready = 1;
    samp();
    chk("t5 abort", flags(), 9'b000001000);
    cyc();
    samp();
    chk("t5 c1 beat", flags(), 9'b101000011);
    chk("t5 c1 data", bus_data, 8'h77);
    cyc();
    gnt_1 = 0;
    samp();
    chk("t5 c1 done", flags(), 9'b000010011);
    cyc();
    samp();
    chk("t5 release", busy, 1'b1);
    cyc();
    samp();
    chk("t5 idle", busy, 1'b0);
    chk("t5 c0 beats", nb0, 2);
    chk("t5 abort count", nab, 1);
    chk("t5 no done_0", nd0, 0);

    // random bursts against a transaction-level expectation
    for (int t = 0; t < 40; t++) begin
      o    = int'($urandom_range(0, 1));
      len  = int'($urandom_range(0, 15));
      base = DW'($urandom_range(0, 255));
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(DW'(int'(base) + i));
      cyc();
      gnt_0 = (o == 0); gnt_1 = (o == 1);
      if (o == 0) begin len_0 = LW'(len); data_0 = base; end
      else begin len_1 = LW'(len); data_1 = base; end
      bus_ready = ($urandom_range(0, 3) != 0);
      first = 1; done_due = 0; fin = 0; cycles = 0;
      while (!fin && cycles < 200) begin
        if (!first) begin
          cyc();
          bus_ready = ($urandom_range(0, 3) != 0);
        end
        samp();
        got_done = (o == 1) ? done_1 : done_0;
        got_beat = (o == 1) ? beat_1 : beat_0;
        oth_done = (o == 1) ? done_0 : done_1;
        oth_beat = (o == 1) ? beat_0 : beat_1;
        chk("rnd done", got_done, done_due);
        chk("rnd valid", bus_valid, !first && !done_due && (exp_q.size() > 0));
        chk("rnd stray", {oth_beat, oth_done, abort, err}, 4'b0);
        if (got_beat) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rnd extra beat: got data %0h expected no beat", bus_data);
          end else begin
            chk("rnd data", bus_data, exp_q.pop_front());
          end
        end else if (bus_valid && exp_q.size() > 0) begin
          chk("rnd hold", bus_data, exp_q[0]);
        end
        if (done_due) fin = 1;
        else done_due = (first && len == 0) || (got_beat && exp_q.size() == 0);
        first = 0;
        cycles++;
      end
      if (!fin) begin
        n_cmp++; n_err++;
        $display("FAIL rnd timeout: got no done in 200 cycles expected done (tx %0d)", t);
      end
      h = int'($urandom_range(0, 2));
      repeat (h) begin
        cyc();
        samp();
        chk("rnd release hold", busy, 1'b1);
      end
      cyc();
      gnt_0 = 0; gnt_1 = 0;
      samp();
      chk("rnd release exit", busy, 1'b1);
      cyc();
      samp();
      chk("rnd idle", busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
